mips_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences a shared-memory MIPS datapath: one memory port serves both fetch and load/store, with one ALU and one regfile.
- Replaces the per-cycle combinational decode of the single-cycle machine.
- Drives datapath enables and mux selects, handshakes with a variable-latency memory, and counts retired instructions.
- Instantiated inside the machine between the instruction register (IR) and the datapath.

---
 rtl/mips_multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared memory port and counts retired instructions; illegal ops may trap.
// Ports:
//   in:  clk, reset (async, active-low), opcode, funct, zero, mem_ready
//   out: mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond, PCSrc,
//        ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, MemToReg,
//        state, trap, retired
module mips_multicycle_ctrl #(
  parameter int CNT_W           = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic             MemToReg,
  output logic [2:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [5:0] OP_R      = 6'h00;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;
  localparam logic [5:0] OP_SWPLUS = 6'h3b;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  logic is_r, is_beq, is_addi, is_lw, is_sw, is_swplus;
  logic is_mem, f_legal, legal;
  logic [2:0] r_aluop;

  assign is_r      = (opcode == OP_R);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_addi   = (opcode == OP_ADDI);
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_swplus = (opcode == OP_SWPLUS);
  assign is_mem    = is_lw | is_sw | is_swplus;

  always_comb begin
    r_aluop = ALU_ADD;
    f_legal = 1'b1;
    unique case (1'b1)
      (funct == 6'h20): r_aluop = ALU_ADD;
      (funct == 6'h22): r_aluop = ALU_SUB;
      (funct == 6'h24): r_aluop = ALU_AND;
      (funct == 6'h25): r_aluop = ALU_OR;
      (funct == 6'h26): r_aluop = ALU_XOR;
      (funct == 6'h27): r_aluop = ALU_NOR;
      default:          f_legal = 1'b0;
    endcase
  end

  assign legal = (is_r & f_legal) | is_beq | is_addi | is_mem;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE:
        if (legal)                state_d = S_EXEC;
        else if (TRAP_ON_ILLEGAL) state_d = S_TRAP;
        else                      state_d = S_FETCH;
      S_EXEC:
        if (is_beq) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      S_MEM:
        if (mem_ready) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Outputs are forced to defaults while reset is low so a pending memory
  // request is withdrawn in the same cycle reset asserts.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = ALU_ADD;
    RegWrite    = 1'b0;
    RegDst      = 2'd0;
    MemToReg    = 1'b0;
    if (reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = 2'd1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'd3;
        S_EXEC: begin
          ALUSrcA = 1'b1;
          if (is_r) begin
            ALUOp = r_aluop;
          end else if (is_beq) begin
            ALUOp       = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSrc       = 1'b1;
          end else begin
            ALUSrcB = 2'd2;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          mem_we   = is_sw | is_swplus;
          RegWrite = is_lw & mem_ready;
        end
        S_WB: begin
          RegWrite = 1'b1;
          if (is_r)           RegDst = 2'd1;
          else if (is_swplus) RegDst = 2'd2;
          MemToReg = is_lw;
        end
        S_TRAP:  ;
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign trap    = (state_q == S_TRAP);
  assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl: default instance plus a
// no-trap instance and a 4-bit counter instance sharing the same stimulus.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic a_mem_req, b_mem_req, c_mem_req;
  logic a_mem_we, b_mem_we, c_mem_we;
  logic a_IorD, b_IorD, c_IorD;
  logic a_IRWrite, b_IRWrite, c_IRWrite;
  logic a_PCWrite, b_PCWrite, c_PCWrite;
  logic a_PCWriteCond, b_PCWriteCond, c_PCWriteCond;
  logic a_PCSrc, b_PCSrc, c_PCSrc;
  logic a_ALUSrcA, b_ALUSrcA, c_ALUSrcA;
  logic [1:0] a_ALUSrcB, b_ALUSrcB, c_ALUSrcB;
  logic [2:0] a_ALUOp, b_ALUOp, c_ALUOp;
  logic a_RegWrite, b_RegWrite, c_RegWrite;
  logic [1:0] a_RegDst, b_RegDst, c_RegDst;
  logic a_MemToReg, b_MemToReg, c_MemToReg;
  logic [2:0] a_state, b_state, c_state;
  logic a_trap, b_trap, c_trap;
  logic [31:0] a_retired, b_retired;
  logic [3:0]  c_retired;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .IorD(a_IorD),
    .IRWrite(a_IRWrite), .PCWrite(a_PCWrite),
    .PCWriteCond(a_PCWriteCond), .PCSrc(a_PCSrc),
    .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp),
    .RegWrite(a_RegWrite), .RegDst(a_RegDst), .MemToReg(a_MemToReg),
    .state(a_state), .trap(a_trap), .retired(a_retired)
  );

  mips_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) u_nt (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .IorD(b_IorD),
    .IRWrite(b_IRWrite), .PCWrite(b_PCWrite),
    .PCWriteCond(b_PCWriteCond), .PCSrc(b_PCSrc),
    .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp),
    .RegWrite(b_RegWrite), .RegDst(b_RegDst), .MemToReg(b_MemToReg),
    .state(b_state), .trap(b_trap), .retired(b_retired)
  );

  mips_multicycle_ctrl #(.CNT_W(4)) u_c4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(c_mem_req), .mem_we(c_mem_we), .IorD(c_IorD),
    .IRWrite(c_IRWrite), .PCWrite(c_PCWrite),
    .PCWriteCond(c_PCWriteCond), .PCSrc(c_PCSrc),
    .ALUSrcA(c_ALUSrcA), .ALUSrcB(c_ALUSrcB), .ALUOp(c_ALUOp),
    .RegWrite(c_RegWrite), .RegDst(c_RegDst), .MemToReg(c_MemToReg),
    .state(c_state), .trap(c_trap), .retired(c_retired)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Leaves the bench at a falling edge with the FSM in FETCH.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    n_assert++;
    if (a_state !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_state: got %0d want 0", a_state);
    end
    n_assert++;
    if (a_mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mem_req: got %0b want 0", a_mem_req);
    end
    n_assert++;
    if (a_retired !== 32'd0 || a_ALUOp !== 3'd2) begin
      n_fail++;
      $display("FAIL rst_defaults: retired %0d aluop %0d want 0/2",
               a_retired, a_ALUOp);
    end
    reset = 1'b1;
  endtask

  task automatic test_add();
    logic [2:0] es [5];
    es = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    opcode = 6'h00;
    funct = 6'h20;
    mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_assert++;
      if (a_state !== es[i]) begin
        n_fail++;
        $display("FAIL add_state[%0d]: got %0d want %0d", i, a_state, es[i]);
      end
      if (i == 2) begin
        n_assert++;
        if (a_ALUOp !== 3'd2) begin
          n_fail++;
          $display("FAIL add_aluop: got %0d want 2", a_ALUOp);
        end
      end
      if (i == 3) begin
        n_assert++;
        if (a_RegDst !== 2'd1 || a_RegWrite !== 1'b1) begin
          n_fail++;
          $display("FAIL add_wb: regdst %0d regwrite %0b want 1/1",
                   a_RegDst, a_RegWrite);
        end
      end
    end
    n_assert++;
    if (a_retired !== 32'd1) begin
      n_fail++;
      $display("FAIL add_retired: got %0d want 1", a_retired);
    end
  endtask

  task automatic test_lw();
    logic [2:0] es [9];
    logic [31:0] r0;
    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    r0 = a_retired;
    opcode = 6'h23;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = !(i >= 3 && i <= 5);
      #1;
      n_assert++;
      if (a_state !== es[i]) begin
        n_fail++;
        $display("FAIL lw_state[%0d]: got %0d want %0d", i, a_state, es[i]);
      end
      if (i >= 3 && i <= 6) begin
        n_assert++;
        if (a_IorD !== 1'b1 || a_mem_we !== 1'b0 || a_mem_req !== 1'b1) begin
          n_fail++;
          $display("FAIL lw_mem[%0d]: iord %0b we %0b req %0b want 1/0/1",
                   i, a_IorD, a_mem_we, a_mem_req);
        end
        n_assert++;
        if (a_RegWrite !== (i == 6)) begin
          n_fail++;
          $display("FAIL lw_mem_regwrite[%0d]: got %0b", i, a_RegWrite);
        end
      end
      if (i == 7) begin
        n_assert++;
        if (a_MemToReg !== 1'b1 || a_RegDst !== 2'd0 || a_RegWrite !== 1'b1)
        begin
          n_fail++;
          $display("FAIL lw_wb: m2r %0b regdst %0d rw %0b want 1/0/1",
                   a_MemToReg, a_RegDst, a_RegWrite);
        end
      end
    end
    n_assert++;
    if (a_retired !== r0 + 32'd1) begin
      n_fail++;
      $display("FAIL lw_retired: got %0d want %0d", a_retired, r0 + 1);
    end
  endtask

  task automatic test_beq();
    logic [2:0] es [4];
    logic [31:0] r0;
    es = '{3'd0, 3'd1, 3'd2, 3'd0};
    r0 = a_retired;
    opcode = 6'h04;
    mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        n_assert++;
        if (a_state !== es[i]) begin
          n_fail++;
          $display("FAIL beq%0d_state[%0d]: got %0d want %0d",
                   z, i, a_state, es[i]);
        end
        if (i == 2) begin
          n_assert++;
          if (a_PCWriteCond !== 1'b1 || a_PCSrc !== 1'b1 || a_ALUOp !== 3'd3)
          begin
            n_fail++;
            $display("FAIL beq%0d_exec: pwc %0b src %0b aluop %0d want 1/1/3",
                     z, a_PCWriteCond, a_PCSrc, a_ALUOp);
          end
        end
      end
    end
    n_assert++;
    if (a_retired !== r0 + 32'd2) begin
      n_fail++;
      $display("FAIL beq_retired: got %0d want %0d", a_retired, r0 + 2);
    end
  endtask

  task automatic test_store();
    logic [2:0] ep [6];
    logic [2:0] es [5];
    logic [31:0] r0;
    ep = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    r0 = a_retired;
    mem_ready = 1'b1;
    opcode = 6'h3b;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_assert++;
      if (a_state !== ep[i]) begin
        n_fail++;
        $display("FAIL swp_state[%0d]: got %0d want %0d", i, a_state, ep[i]);
      end
      if (i == 3) begin
        n_assert++;
        if (a_mem_we !== 1'b1) begin
          n_fail++;
          $display("FAIL swp_we: got %0b want 1", a_mem_we);
        end
      end
      if (i == 4) begin
        n_assert++;
        if (a_RegDst !== 2'd2 || a_RegWrite !== 1'b1) begin
          n_fail++;
          $display("FAIL swp_wb: regdst %0d rw %0b want 2/1",
                   a_RegDst, a_RegWrite);
        end
      end
    end
    opcode = 6'h2b;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_assert++;
      if (a_state !== es[i]) begin
        n_fail++;
        $display("FAIL sw_state[%0d]: got %0d want %0d", i, a_state, es[i]);
      end
      if (i == 3) begin
        n_assert++;
        if (a_mem_we !== 1'b1 || a_IorD !== 1'b1) begin
          n_fail++;
          $display("FAIL sw_mem: we %0b iord %0b want 1/1", a_mem_we, a_IorD);
        end
      end
    end
    n_assert++;
    if (a_retired !== r0 + 32'd2) begin
      n_fail++;
      $display("FAIL store_retired: got %0d want %0d", a_retired, r0 + 2);
    end
  endtask

  task automatic test_reset_mid_mem();
    opcode = 6'h23;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = (i < 3);
      #1;
    end
    n_assert++;
    if (a_state !== 3'd3 || a_mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: state %0d req %0b want 3/1", a_state, a_mem_req);
    end
    #1;
    reset = 1'b0;
    #1;
    n_assert++;
    if (a_mem_req !== 1'b0 || a_state !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_rst: req %0b state %0d want 0/0", a_mem_req, a_state);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_assert++;
    if (a_state !== 3'd0 || a_retired !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_post: state %0d retired %0d want 0/0",
               a_state, a_retired);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ra, rb;
    ra = a_retired;
    rb = b_retired;
    opcode = 6'h3f;
    mem_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (i >= 2) begin
        n_assert++;
        if (a_state !== 3'd5 || a_trap !== 1'b1 || a_mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL trap[%0d]: state %0d trap %0b req %0b want 5/1/0",
                   i, a_state, a_trap, a_mem_req);
        end
      end
      if (i == 2) begin
        n_assert++;
        if (b_state !== 3'd0 || b_trap !== 1'b0) begin
          n_fail++;
          $display("FAIL notrap_state: state %0d trap %0b want 0/0",
                   b_state, b_trap);
        end
      end
    end
    n_assert++;
    if (a_retired !== ra || b_retired !== rb) begin
      n_fail++;
      $display("FAIL illegal_retired: a %0d b %0d want %0d %0d",
               a_retired, b_retired, ra, rb);
    end
  endtask

  task automatic test_cnt_wrap();
    opcode = 6'h04;
    zero = 1'b0;
    mem_ready = 1'b1;
    do_reset();
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      #1;
      if (i == 45) begin
        n_assert++;
        if (c_retired !== 4'd15) begin
          n_fail++;
          $display("FAIL cnt4_15: got %0d want 15", c_retired);
        end
      end
    end
    n_assert++;
    if (c_retired !== 4'd0 || a_retired !== 32'd16) begin
      n_fail++;
      $display("FAIL cnt4_wrap: c %0d a %0d want 0/16", c_retired, a_retired);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_store();
    test_reset_mid_mem();
    test_illegal();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
